// File: rtl/reservation_station.sv
// reservation_station: holds arithmetic/branch micro-ops until both source
// operands are known, snoops the ALU and LSB result buses, and issues the
// lowest-index ready entry to the ALU once per cycle.
//
// Handshake: there is no back-pressure in either direction. Dispatch writes
// slot disp_pos on any rdy_in cycle with disp_en=1 and full=0; a write seen
// while full=1 is dropped. Issue is a one-cycle alu_en strobe that the ALU
// must accept unconditionally; alu_* hold their last value while alu_en=0.
module reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int RS_W    = 4,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             disp_en,
  input  logic [RS_W-1:0]  disp_pos,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [31:0]      disp_a,
  input  logic [31:0]      disp_pc,
  input  logic [ROB_W-1:0] disp_reorder,
  input  logic             disp_type_j,
  input  logic [31:0]      disp_value_j,
  input  logic             disp_type_k,
  input  logic [31:0]      disp_value_k,
  input  logic             alu_cdb_en,
  input  logic [ROB_W-1:0] alu_cdb_reorder,
  input  logic [31:0]      alu_cdb_value,
  input  logic             lsb_cdb_en,
  input  logic [ROB_W-1:0] lsb_cdb_reorder,
  input  logic [31:0]      lsb_cdb_value,
  output logic [RS_W-1:0]  free_pos,
  output logic             full,
  output logic             alu_en,
  output logic [OP_W-1:0]  alu_op,
  output logic [31:0]      alu_vj,
  output logic [31:0]      alu_vk,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_pc,
  output logic [ROB_W-1:0] alu_reorder
);

  // Entry storage. While q*_wait is set, the low ROB_W bits of v* hold the tag.
  logic             busy_q    [RS_SIZE];
  logic             busy_d    [RS_SIZE];
  logic [OP_W-1:0]  op_q      [RS_SIZE];
  logic [OP_W-1:0]  op_d      [RS_SIZE];
  logic [31:0]      a_q       [RS_SIZE];
  logic [31:0]      a_d       [RS_SIZE];
  logic [31:0]      pc_q      [RS_SIZE];
  logic [31:0]      pc_d      [RS_SIZE];
  logic [ROB_W-1:0] reorder_q [RS_SIZE];
  logic [ROB_W-1:0] reorder_d [RS_SIZE];
  logic             qj_wait_q [RS_SIZE];
  logic             qj_wait_d [RS_SIZE];
  logic [31:0]      vj_q      [RS_SIZE];
  logic [31:0]      vj_d      [RS_SIZE];
  logic             qk_wait_q [RS_SIZE];
  logic             qk_wait_d [RS_SIZE];
  logic [31:0]      vk_q      [RS_SIZE];
  logic [31:0]      vk_d      [RS_SIZE];

  logic             alu_en_q,      alu_en_d;
  logic [OP_W-1:0]  alu_op_q,      alu_op_d;
  logic [31:0]      alu_vj_q,      alu_vj_d;
  logic [31:0]      alu_vk_q,      alu_vk_d;
  logic [31:0]      alu_a_q,       alu_a_d;
  logic [31:0]      alu_pc_q,      alu_pc_d;
  logic [ROB_W-1:0] alu_reorder_q, alu_reorder_d;

  logic             sel_valid;
  logic [RS_W-1:0]  sel_idx;
  logic [32:0]      disp_j_res;
  logic [32:0]      disp_k_res;

  // Resolve one operand against both buses. Returns {still_waiting, value}.
  // The ALU bus is checked first so it wins a (never legal) double match.
  function automatic logic [32:0] snoop(input logic wait_in, input logic [31:0] v_in);
    logic [32:0] r;
    r = {wait_in, v_in};
    if (wait_in) begin
      if (alu_cdb_en && (alu_cdb_reorder == v_in[ROB_W-1:0])) begin
        r = {1'b0, alu_cdb_value};
      end else if (lsb_cdb_en && (lsb_cdb_reorder == v_in[ROB_W-1:0])) begin
        r = {1'b0, lsb_cdb_value};
      end
    end
    return r;
  endfunction

  // Lowest-index free slot and the full flag, from registered busy bits only.
  always_comb begin
    free_pos = '0;
    full     = 1'b1;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_pos = RS_W'(i);
        full     = 1'b0;
      end
    end
  end

  // Lowest-index ready entry, from registered state only (no same-cycle wakeup).
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (busy_q[i] && !qj_wait_q[i] && !qk_wait_q[i]) begin
        sel_valid = 1'b1;
        sel_idx   = RS_W'(i);
      end
    end
  end

  // Incoming operands with same-cycle bus forwarding.
  always_comb begin
    disp_j_res = snoop(disp_type_j, disp_value_j);
    disp_k_res = snoop(disp_type_k, disp_value_k);
  end

  // Next state: flush, freeze, or wakeup + issue + dispatch.
  always_comb begin
    busy_d        = busy_q;
    op_d          = op_q;
    a_d           = a_q;
    pc_d          = pc_q;
    reorder_d     = reorder_q;
    qj_wait_d     = qj_wait_q;
    vj_d          = vj_q;
    qk_wait_d     = qk_wait_q;
    vk_d          = vk_q;
    alu_en_d      = 1'b0;
    alu_op_d      = alu_op_q;
    alu_vj_d      = alu_vj_q;
    alu_vk_d      = alu_vk_q;
    alu_a_d       = alu_a_q;
    alu_pc_d      = alu_pc_q;
    alu_reorder_d = alu_reorder_q;

    if (clear_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        busy_d[i] = 1'b0;
      end
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i]) begin
          {qj_wait_d[i], vj_d[i]} = snoop(qj_wait_q[i], vj_q[i]);
          {qk_wait_d[i], vk_d[i]} = snoop(qk_wait_q[i], vk_q[i]);
        end
      end

      if (sel_valid) begin
        alu_en_d          = 1'b1;
        alu_op_d          = op_q[sel_idx];
        alu_vj_d          = vj_q[sel_idx];
        alu_vk_d          = vk_q[sel_idx];
        alu_a_d           = a_q[sel_idx];
        alu_pc_d          = pc_q[sel_idx];
        alu_reorder_d     = reorder_q[sel_idx];
        busy_d[sel_idx]   = 1'b0;
      end

      // The dispatch target is a free slot, so it never collides with the issuer.
      if (disp_en && !full) begin
        busy_d[disp_pos]    = 1'b1;
        op_d[disp_pos]      = disp_op;
        a_d[disp_pos]       = disp_a;
        pc_d[disp_pos]      = disp_pc;
        reorder_d[disp_pos] = disp_reorder;
        {qj_wait_d[disp_pos], vj_d[disp_pos]} = disp_j_res;
        {qk_wait_d[disp_pos], vk_d[disp_pos]} = disp_k_res;
      end
    end
  end

  // State registers; only busy bits and issue outputs need reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        busy_q[i] <= 1'b0;
      end
      alu_en_q      <= 1'b0;
      alu_op_q      <= '0;
      alu_vj_q      <= '0;
      alu_vk_q      <= '0;
      alu_a_q       <= '0;
      alu_pc_q      <= '0;
      alu_reorder_q <= '0;
    end else begin
      busy_q        <= busy_d;
      alu_en_q      <= alu_en_d;
      alu_op_q      <= alu_op_d;
      alu_vj_q      <= alu_vj_d;
      alu_vk_q      <= alu_vk_d;
      alu_a_q       <= alu_a_d;
      alu_pc_q      <= alu_pc_d;
      alu_reorder_q <= alu_reorder_d;
    end
    op_q      <= op_d;
    a_q       <= a_d;
    pc_q      <= pc_d;
    reorder_q <= reorder_d;
    qj_wait_q <= qj_wait_d;
    vj_q      <= vj_d;
    qk_wait_q <= qk_wait_d;
    vk_q      <= vk_d;
  end

  assign alu_en      = alu_en_q;
  assign alu_op      = alu_op_q;
  assign alu_vj      = alu_vj_q;
  assign alu_vk      = alu_vk_q;
  assign alu_a       = alu_a_q;
  assign alu_pc      = alu_pc_q;
  assign alu_reorder = alu_reorder_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: a vector table for single-entry
// dispatch/forwarding cases plus hand-written multi-cycle sequences.
module tb_reservation_station;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in;
  logic        disp_en;
  logic [3:0]  disp_pos;
  logic [5:0]  disp_op;
  logic [31:0] disp_a, disp_pc;
  logic [3:0]  disp_reorder;
  logic        disp_type_j, disp_type_k;
  logic [31:0] disp_value_j, disp_value_k;
  logic        alu_cdb_en, lsb_cdb_en;
  logic [3:0]  alu_cdb_reorder, lsb_cdb_reorder;
  logic [31:0] alu_cdb_value, lsb_cdb_value;
  logic [3:0]  free_pos;
  logic        full, alu_en;
  logic [5:0]  alu_op;
  logic [31:0] alu_vj, alu_vk, alu_a, alu_pc;
  logic [3:0]  alu_reorder;

  int total = 0;
  int bad   = 0;

  reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .disp_en(disp_en), .disp_pos(disp_pos), .disp_op(disp_op), .disp_a(disp_a),
    .disp_pc(disp_pc), .disp_reorder(disp_reorder),
    .disp_type_j(disp_type_j), .disp_value_j(disp_value_j),
    .disp_type_k(disp_type_k), .disp_value_k(disp_value_k),
    .alu_cdb_en(alu_cdb_en), .alu_cdb_reorder(alu_cdb_reorder), .alu_cdb_value(alu_cdb_value),
    .lsb_cdb_en(lsb_cdb_en), .lsb_cdb_reorder(lsb_cdb_reorder), .lsb_cdb_value(lsb_cdb_value),
    .free_pos(free_pos), .full(full), .alu_en(alu_en), .alu_op(alu_op),
    .alu_vj(alu_vj), .alu_vk(alu_vk), .alu_a(alu_a), .alu_pc(alu_pc),
    .alu_reorder(alu_reorder)
  );

  // Clock
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a, pc;
    logic [3:0]  rob;
    logic        tj;
    logic [31:0] vj;
    logic        tk;
    logic [31:0] vk;
    logic        ae;
    logic [3:0]  at;
    logic [31:0] av;
    logic        le;
    logic [3:0]  lt;
    logic [31:0] lv;
    logic [31:0] exp_vj, exp_vk;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    disp_en    = 1'b0;
    clear_in   = 1'b0;
    alu_cdb_en = 1'b0;
    lsb_cdb_en = 1'b0;
  endtask

  task automatic disp(input logic [3:0] pos, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] pc, input logic [3:0] rob,
                      input logic tj, input logic [31:0] vj,
                      input logic tk, input logic [31:0] vk);
    disp_en      = 1'b1;
    disp_pos     = pos;
    disp_op      = op;
    disp_a       = a;
    disp_pc      = pc;
    disp_reorder = rob;
    disp_type_j  = tj;
    disp_value_j = vj;
    disp_type_k  = tk;
    disp_value_k = vk;
  endtask

  task automatic alu_bc(input logic [3:0] tag, input logic [31:0] val);
    alu_cdb_en = 1'b1; alu_cdb_reorder = tag; alu_cdb_value = val;
  endtask

  task automatic lsb_bc(input logic [3:0] tag, input logic [31:0] val);
    lsb_cdb_en = 1'b1; lsb_cdb_reorder = tag; lsb_cdb_value = val;
  endtask

  initial begin
    //            op     a             pc          rob tj vj            tk vk            ae at val           le lt val           exp_vj        exp_vk
    vecs[0] = '{6'h01, 32'h0,        32'h100,    4'd2, 0, 32'd5,        0, 32'd7,        0, 4'd0, 32'h0,        0, 4'd0, 32'h0,        32'd5,        32'd7};
    vecs[1] = '{6'h13, 32'hFFFFF800, 32'h200,    4'd15, 0, 32'hFFFFFFFF, 0, 32'h80000000, 0, 4'd0, 32'h0,       0, 4'd0, 32'h0,        32'hFFFFFFFF, 32'h80000000};
    vecs[2] = '{6'h05, 32'h4,        32'h300,    4'd7, 0, 32'h11,       1, 32'd6,        0, 4'd0, 32'h0,        1, 4'd6, 32'hABCD,     32'h11,       32'hABCD};
    vecs[3] = '{6'h22, 32'h8,        32'h400,    4'd1, 1, 32'hFFFFFF03, 0, 32'd9,        1, 4'd3, 32'h1234,     0, 4'd0, 32'h0,        32'h1234,     32'd9};
    vecs[4] = '{6'h3F, 32'hC,        32'hFFFFFFFC, 4'd8, 1, 32'd4,      1, 32'd5,        1, 4'd4, 32'hAAAA5555, 1, 4'd5, 32'h0F0F0F0F, 32'hAAAA5555,  32'h0F0F0F0F};

    rst_in = 1'b1; rdy_in = 1'b1;
    idle();
    disp_pos = '0; disp_op = '0; disp_a = '0; disp_pc = '0; disp_reorder = '0;
    disp_type_j = 1'b0; disp_value_j = '0; disp_type_k = 1'b0; disp_value_k = '0;
    alu_cdb_reorder = '0; alu_cdb_value = '0; lsb_cdb_reorder = '0; lsb_cdb_value = '0;

    // Reset held for two edges
    step(); step();
    chk("rst alu_en", alu_en, 0);
    chk("rst full", full, 0);
    chk("rst free_pos", free_pos, 0);
    chk("rst alu_op", alu_op, 0);
    chk("rst alu_vj", alu_vj, 0);
    chk("rst alu_vk", alu_vk, 0);
    chk("rst alu_a", alu_a, 0);
    chk("rst alu_pc", alu_pc, 0);
    chk("rst alu_reorder", alu_reorder, 0);
    rst_in = 1'b0;

    // Table: single dispatch, operands ready or forwarded the same cycle
    for (int v = 0; v < 5; v++) begin
      disp(4'd0, vecs[v].op, vecs[v].a, vecs[v].pc, vecs[v].rob,
           vecs[v].tj, vecs[v].vj, vecs[v].tk, vecs[v].vk);
      if (vecs[v].ae) alu_bc(vecs[v].at, vecs[v].av);
      if (vecs[v].le) lsb_bc(vecs[v].lt, vecs[v].lv);
      step();
      idle();
      chk($sformatf("v%0d no early issue", v), alu_en, 0);
      chk($sformatf("v%0d slot0 busy", v), free_pos, 1);
      step();
      chk($sformatf("v%0d alu_en", v), alu_en, 1);
      chk($sformatf("v%0d alu_op", v), alu_op, vecs[v].op);
      chk($sformatf("v%0d alu_vj", v), alu_vj, vecs[v].exp_vj);
      chk($sformatf("v%0d alu_vk", v), alu_vk, vecs[v].exp_vk);
      chk($sformatf("v%0d alu_a", v), alu_a, vecs[v].a);
      chk($sformatf("v%0d alu_pc", v), alu_pc, vecs[v].pc);
      chk($sformatf("v%0d alu_reorder", v), alu_reorder, vecs[v].rob);
      chk($sformatf("v%0d freed", v), free_pos, 0);
      step();
      chk($sformatf("v%0d strobe drops", v), alu_en, 0);
      chk($sformatf("v%0d vj held", v), alu_vj, vecs[v].exp_vj);
    end

    // Wakeup: j waits on tag 3; an unrelated LSB tag 5 must not wake it
    disp(4'd0, 6'h01, 32'h0, 32'h500, 4'd4, 1'b1, 32'd3, 1'b0, 32'd1);
    step();
    idle();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("wake idle %0d", c), alu_en, 0);
      if (c == 1) lsb_bc(4'd5, 32'hBAD);
      step();
      idle();
    end
    chk("wake pre bc", alu_en, 0);
    alu_bc(4'd3, 32'h55);
    step();
    idle();
    chk("wake edge no issue", alu_en, 0);
    step();
    chk("wake alu_en", alu_en, 1);
    chk("wake alu_vj", alu_vj, 32'h55);
    chk("wake alu_vk", alu_vk, 32'd1);
    chk("wake alu_reorder", alu_reorder, 4);
    step();

    // Full: 16 entries waiting on tag 9, then in-order drain
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fill free_pos %0d", i), free_pos, i);
      chk($sformatf("fill not full %0d", i), full, 0);
      disp(4'(i), 6'h02, 32'(i), 32'h1000 + 32'(i), 4'(i), 1'b1, 32'd9, 1'b0, 32'h100 + 32'(i));
      step();
    end
    idle();
    chk("full flag", full, 1);
    chk("full free_pos", free_pos, 0);
    // A write while full is dropped; were it stored, it would issue next edge
    disp(4'd0, 6'h07, 32'h0, 32'h0, 4'd0, 1'b0, 32'hDEAD, 1'b0, 32'hDEAD);
    step();
    idle();
    alu_bc(4'd9, 32'h99);
    step();
    idle();
    chk("full ignored write", alu_en, 0);
    chk("full after wake", full, 1);
    for (int k = 0; k < 16; k++) begin
      step();
      chk($sformatf("drain en %0d", k), alu_en, 1);
      chk($sformatf("drain vj %0d", k), alu_vj, 32'h99);
      chk($sformatf("drain vk %0d", k), alu_vk, 32'h100 + 32'(k));
      chk($sformatf("drain rob %0d", k), alu_reorder, k);
      chk($sformatf("drain full %0d", k), full, 0);
      chk($sformatf("drain free_pos %0d", k), free_pos, 0);
    end
    step();
    chk("drain done", alu_en, 0);

    // Flush: 4 waiting entries; clear_in with a dispatch and a matching CDB
    for (int i = 0; i < 4; i++) begin
      disp(4'(i), 6'h03, 32'h0, 32'h0, 4'(i), 1'b1, 32'd10, 1'b0, 32'h0);
      step();
    end
    idle();
    chk("pre flush free_pos", free_pos, 4);
    disp(4'd4, 6'h04, 32'h0, 32'h0, 4'd4, 1'b0, 32'h1, 1'b0, 32'h2);
    alu_bc(4'd10, 32'hF00D);
    clear_in = 1'b1;
    step();
    idle();
    chk("flush full", full, 0);
    chk("flush free_pos", free_pos, 0);
    chk("flush alu_en", alu_en, 0);
    alu_bc(4'd10, 32'hF00D);
    step();
    idle();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("flush silent %0d", c), alu_en, 0);
      step();
    end

    // Freeze: rdy_in low holds state and suppresses issue
    disp(4'd0, 6'h09, 32'h0, 32'h0, 4'd5, 1'b0, 32'h77, 1'b0, 32'h88);
    step();
    idle();
    rdy_in = 1'b0;
    step();
    chk("freeze en 1", alu_en, 0);
    chk("freeze free_pos", free_pos, 1);
    chk("freeze alu_vk held", alu_vk, 32'h10F);
    step();
    chk("freeze en 2", alu_en, 0);
    rdy_in = 1'b1;
    step();
    chk("thaw alu_en", alu_en, 1);
    chk("thaw alu_vj", alu_vj, 32'h77);
    chk("thaw alu_vk", alu_vk, 32'h88);
    chk("thaw alu_reorder", alu_reorder, 5);

    // Reset mid-operation: the ready entry is lost
    disp(4'd0, 6'h0A, 32'h0, 32'h0, 4'd6, 1'b0, 32'h1, 1'b0, 32'h2);
    step();
    idle();
    rst_in = 1'b1;
    step();
    chk("midrst alu_en", alu_en, 0);
    chk("midrst alu_vj", alu_vj, 0);
    chk("midrst free_pos", free_pos, 0);
    rst_in = 1'b0;
    step();
    chk("midrst no issue", alu_en, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
# reservation_station

Arithmetic/branch reservation station. Receives non-memory micro-ops from the dispatch stage, holds them until both source operands are resolved, snoops the two common data buses (ALU and LSB) for ROB-tagged results, and issues one ready entry per cycle to the ALU. It publishes its free slot index and full flag back to dispatch.

## Interface
- RS_SIZE, 16: number of entries (power of two).
- RS_W, 4: log2(RS_SIZE), slot index width.
- ROB_W, 4: ROB tag width.
- OP_W, 6: opcode width.
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  reset, synchronous, active-high.
- rdy_in  in  1  global enable; low = freeze.
- clear_in  in  1  flush on mispredict; invalidates all entries.
- disp_en  in  1  write one entry this cycle.
- disp_pos  in  RS_W  target slot; always equal to free_pos.
- disp_op / disp_a / disp_pc / disp_reorder  in  OP_W/32/32/ROB_W  opcode, immediate, pc, destination ROB tag.
- disp_type_j / disp_value_j  in  1/32  0 = value valid; 1 = value[ROB_W-1:0] is a pending ROB tag. Same for _k.
- alu_cdb_en / alu_cdb_reorder / alu_cdb_value  in  1/ROB_W/32  ALU result broadcast.
- lsb_cdb_en / lsb_cdb_reorder / lsb_cdb_value  in  1/ROB_W/32  load result broadcast.
- free_pos  out  RS_W  lowest-index free slot (0 when full).
- full  out  1  no free slot.
- alu_en  out  1  issue strobe, one cycle.
- alu_op / alu_vj / alu_vk / alu_a / alu_pc / alu_reorder  out  OP_W/32/32/32/32/ROB_W  issued entry.

## Operation
- Per entry state: busy, op, a, pc, reorder, qj_wait, vj, qk_wait, vk. Ready = busy & !qj_wait & !qk_wait.
- free_pos/full: combinational from registered busy bits; lowest-index priority.
- Dispatch: on disp_en, slot disp_pos loaded, busy=1. Writes with full=1 are ignored (upstream error).
- Same-cycle forwarding: if an incoming operand has type=1 and its tag matches an asserted CDB this cycle, it is stored as valid with the CDB value. ALU bus wins if both match (cannot happen legally).
- Wakeup: every busy entry with qX_wait=1 and tag == asserted CDB tag captures the value and clears qX_wait at the edge.
- Select: lowest-index ready entry, computed from registered state only.
- Issue: at the edge, the selected entry's fields are registered onto alu_*, alu_en=1, entry busy cleared. No ready entry: alu_en=0, alu_* hold last values.
- Operand values are 32-bit, stored unmodified; tags compare on low ROB_W bits only.

## Timing
- Reset (rst_in=1 at edge): all busy=0, alu_en=0, all alu_* = 0; free_pos=0, full=0 follow.
- Priority at edge: rst_in > clear_in > !rdy_in > normal.
- clear_in: all busy=0, alu_en=0; dispatch and CDB that cycle discarded.
- rdy_in=0: state and alu_* held, alu_en forced 0.
- Latency: dispatch with both operands valid at edge N -> alu_en at edge N+1 (earliest). CDB wakeup at edge N -> issue at edge N+1 earliest.
- A slot issuing at edge N is not reported free until after edge N; dispatch never targets it in that cycle.
- Dispatch and issue in the same cycle are independent; at most one issue per cycle.
- Reset mid-operation: all in-flight entries lost, no issue next cycle.

## Test plan
- Reset: assert rst_in 2 cycles -> alu_en=0, full=0, free_pos=0, all alu_* = 0.
- Ready dispatch: disp_en, op=ADD, vj=5, vk=7, reorder=2 at edge 1 -> alu_en=1 with alu_vj=5, alu_vk=7, alu_reorder=2 after edge 2; slot 0 free again.
- Wakeup: dispatch type_j=1 tag 3, vk=1; three cycles later alu_cdb tag 3 value 0x55 -> issue next edge with alu_vj=0x55; no issue before.
- Forwarding: dispatch type_k=1 tag 6 while lsb_cdb tag 6 value 0xABCD same cycle -> issue next edge with alu_vk=0xABCD.
- Full/priority: dispatch 16 entries all waiting on tag 9 -> full=1; broadcast tag 9 -> issue slots 0..15 in index order, one per cycle; full drops after the first issue with free_pos=0.
- Flush: 4 busy entries, pulse clear_in together with disp_en -> next cycle full=0, free_pos=0, no alu_en ever produced for flushed entries.
